// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory port, with bounded burst ownership.
// Optional contention counter on stat_conflicts when ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    output logic          m0_gnt,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    output logic          m1_gnt,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   stat_conflicts
`endif
);

    localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BurstLast = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          last_q, last_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            burst_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                burst_d = '0;
                if (m0_req && m1_req) begin
                    // last_q names the previous owner; the other master wins the tie
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (m0_req) begin
                    state_d = StOwn0;
                end else if (m1_req) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!m0_req || (m1_req && burst_q == BurstLast)) begin
                    state_d = m1_req ? StOwn1 : StIdle;
                    burst_d = '0;
                    last_d  = 1'b0;
                end else if (burst_q != BurstLast) begin
                    burst_d = burst_q + CW'(1);
                end
            end
            StOwn1: begin
                if (!m1_req || (m0_req && burst_q == BurstLast)) begin
                    state_d = m0_req ? StOwn0 : StIdle;
                    burst_d = '0;
                    last_d  = 1'b1;
                end else if (burst_q != BurstLast) begin
                    burst_d = burst_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                burst_d = '0;
            end
        endcase
    end

    assign m0_gnt = (state_q == StOwn0);
    assign m1_gnt = (state_q == StOwn1);
    assign rdata  = mem_rdata;

    // mem_we is gated by rst_n so the reset cycle never commits a write
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            StOwn0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we    = m0_we & m0_req & rst_n;
            end
            StOwn1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we    = m1_we & m1_req & rst_n;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    logic [15:0] conflicts_q, conflicts_d;
    logic        conflict;

    assign conflict = (state_q == StOwn0 && m1_req) || (state_q == StOwn1 && m0_req);

    always_comb begin
        conflicts_d = conflicts_q;
        if (conflict && conflicts_q != 16'hFFFF) begin
            conflicts_d = conflicts_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflicts_q <= '0;
        end else begin
            conflicts_q <= conflicts_d;
        end
    end

    assign stat_conflicts = conflicts_q;
`endif

endmodule
